// File: rtl/bru_pkg.sv
// Shared types and sizing helpers for the branch resolution unit.
// The in-flight entry layout is fixed by BRU_PC_W; the top's PC_W must match it.
package bru_pkg;

    localparam int BRU_PC_W  = 10;
    localparam int BRU_DEPTH = 8;
    localparam int BRU_OCC_W = $clog2(BRU_DEPTH) + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bru_state_e;

    typedef struct packed {
        logic [BRU_PC_W-1:0] pc;
        logic                pred;
    } inflight_t;

    // One extra bit so a completely full queue is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bru_inflight_fifo.sv
// In-order queue of issued-but-unresolved branches with a single-cycle clear.
// Head entry is read combinationally so a resolve can compare in its own cycle.
module bru_inflight_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             push,
    input  inflight_t        push_data,
    input  logic             pop,
    output inflight_t        head_data,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    inflight_t mem [0:DEPTH-1];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    // Clear wins over any concurrent push/pop: the whole queue is wrong-path.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr_q];
    assign full      = (count_q == OCC_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/branch_resolution_unit.sv
// Pairs issued branch predictions with resolved outcomes, trains the predictor,
// flags mispredicts and holds off the front end for a fixed redirect penalty.
module branch_resolution_unit
    import bru_pkg::*;
#(
    parameter int PC_W    = BRU_PC_W,
    parameter int DEPTH   = 8,
    parameter int PENALTY = 3,
    parameter int CNT_W   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [PC_W-1:0]          issue_pc,
    input  logic                     issue_pred,
    output logic                     issue_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     resolve_ready,
    output logic                     update_valid,
    output logic [PC_W-1:0]          update_pc,
    output logic                     update_taken,
    output logic                     mispredict,
    output logic                     flushing,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         correct_count,
    output logic [CNT_W-1:0]         mispredict_count
);

    localparam int OCC_W = occ_width(DEPTH);
    localparam int PEN_W = (PENALTY > 1) ? $clog2(PENALTY) : 1;

    bru_state_e       state_q, state_d;
    logic [PEN_W-1:0] pen_cnt_q, pen_cnt_d;

    logic             update_valid_q, update_valid_d;
    logic [PC_W-1:0]  update_pc_q, update_pc_d;
    logic             update_taken_q, update_taken_d;
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] correct_count_q, correct_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    inflight_t        head;
    inflight_t        push_entry;
    logic             fifo_full, fifo_empty;
    logic [OCC_W-1:0] fifo_count;

    logic issue_fire, resolve_fire, mispred_now;

    // Readies are held low while reset is asserted so every output reads 0.
    assign issue_ready   = !reset && (state_q == RUN) && !fifo_full;
    assign resolve_ready = !reset && (state_q == RUN) && !fifo_empty;

    assign issue_fire   = issue_valid && issue_ready;
    assign resolve_fire = resolve_valid && resolve_ready;
    assign mispred_now  = resolve_fire && (head.pred != resolve_taken);

    assign push_entry.pc   = issue_pc;
    assign push_entry.pred = issue_pred;

    // A mispredict clears the queue, which also drops a same-cycle issue.
    bru_inflight_fifo #(
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_fifo (
        .clk       (clock),
        .srst      (reset),
        .clear     (mispred_now),
        .push      (issue_fire && !mispred_now),
        .push_data (push_entry),
        .pop       (resolve_fire && !mispred_now),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d            = state_q;
        pen_cnt_d          = pen_cnt_q;
        update_valid_d     = resolve_fire;
        update_pc_d        = update_pc_q;
        update_taken_d     = update_taken_q;
        mispredict_d       = mispred_now;
        correct_count_d    = correct_count_q;
        mispredict_count_d = mispredict_count_q;

        case (state_q)
            RUN: begin
                if (mispred_now) begin
                    state_d   = FLUSH;
                    pen_cnt_d = '0;
                end
            end
            FLUSH: begin
                if (pen_cnt_q == PEN_W'(PENALTY - 1)) begin
                    state_d   = RUN;
                    pen_cnt_d = '0;
                end else begin
                    pen_cnt_d = pen_cnt_q + PEN_W'(1);
                end
            end
            default: begin
                state_d   = RUN;
                pen_cnt_d = '0;
            end
        endcase

        if (resolve_fire) begin
            update_pc_d    = head.pc;
            update_taken_d = resolve_taken;
            if (mispred_now) begin
                if (mispredict_count_q != {CNT_W{1'b1}})
                    mispredict_count_d = mispredict_count_q + CNT_W'(1);
            end else begin
                if (correct_count_q != {CNT_W{1'b1}})
                    correct_count_d = correct_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= RUN;
            pen_cnt_q          <= '0;
            update_valid_q     <= 1'b0;
            update_pc_q        <= '0;
            update_taken_q     <= 1'b0;
            mispredict_q       <= 1'b0;
            correct_count_q    <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            pen_cnt_q          <= pen_cnt_d;
            update_valid_q     <= update_valid_d;
            update_pc_q        <= update_pc_d;
            update_taken_q     <= update_taken_d;
            mispredict_q       <= mispredict_d;
            correct_count_q    <= correct_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign update_valid     = update_valid_q;
    assign update_pc        = update_pc_q;
    assign update_taken     = update_taken_q;
    assign mispredict       = mispredict_q;
    assign flushing         = (state_q == FLUSH);
    assign occupancy        = fifo_count;
    assign correct_count    = correct_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with 4-bit counters so saturation is reachable.
module tb_branch_resolution_unit;

    logic       clock;
    logic       reset;
    logic       issue_valid;
    logic [9:0] issue_pc;
    logic       issue_pred;
    logic       issue_ready;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       resolve_ready;
    logic       update_valid;
    logic [9:0] update_pc;
    logic       update_taken;
    logic       mispredict;
    logic       flushing;
    logic [3:0] occupancy;
    logic [3:0] correct_count;
    logic [3:0] mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_correct = 0;
    int exp_mis     = 0;

    branch_resolution_unit #(
        .PC_W    (10),
        .DEPTH   (8),
        .PENALTY (3),
        .CNT_W   (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_pc         (issue_pc),
        .issue_pred       (issue_pred),
        .issue_ready      (issue_ready),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .resolve_ready    (resolve_ready),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .mispredict       (mispredict),
        .flushing         (flushing),
        .occupancy        (occupancy),
        .correct_count    (correct_count),
        .mispredict_count (mispredict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; issue_valid = 1'b0; issue_pc = '0; issue_pred = 1'b0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
        repeat (3) step();
        n_checks++; if (update_valid !== 1'b0) begin n_fail++; $display("FAIL reset_update_valid: got %b expected 0", update_valid); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_checks++; if (flushing !== 1'b0) begin n_fail++; $display("FAIL reset_flushing: got %b expected 0", flushing); end
        reset = 1'b0;
        #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
        n_checks++; if (resolve_ready !== 1'b0) begin n_fail++; $display("FAIL reset_resolve_ready: got %b expected 0", resolve_ready); end
        n_checks++; if (correct_count !== 4'd0 || mispredict_count !== 4'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", correct_count, mispredict_count); end
        $display("txn reset: occupancy=%0d issue_ready=%b", occupancy, issue_ready);
    endtask

    task automatic test_basic();
        issue_valid = 1'b1; issue_pc = 10'h010; issue_pred = 1'b1;
        step();
        issue_valid = 1'b0;
        n_checks++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL basic_occ_after_issue: got %0d expected 1", occupancy); end
        n_checks++; if (resolve_ready !== 1'b1) begin n_fail++; $display("FAIL basic_resolve_ready: got %b expected 1", resolve_ready); end
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        step();
        resolve_valid = 1'b0;
        exp_correct = sat_inc(exp_correct);
        n_checks++; if (update_valid !== 1'b1) begin n_fail++; $display("FAIL basic_update_valid: got %b expected 1", update_valid); end
        n_checks++; if (update_pc !== 10'h010) begin n_fail++; $display("FAIL basic_update_pc: got %h expected 010", update_pc); end
        n_checks++; if (update_taken !== 1'b1) begin n_fail++; $display("FAIL basic_update_taken: got %b expected 1", update_taken); end
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL basic_mispredict: got %b expected 0", mispredict); end
        n_checks++; if (correct_count !== 4'(exp_correct)) begin n_fail++; $display("FAIL basic_correct_count: got %0d expected %0d", correct_count, exp_correct); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL basic_occ_after_resolve: got %0d expected 0", occupancy); end
        step();
        n_checks++; if (update_valid !== 1'b0) begin n_fail++; $display("FAIL basic_update_pulse: got %b expected 0", update_valid); end
        $display("txn basic: update_pc=%h correct=%0d", update_pc, correct_count);
    endtask

    task automatic test_full();
        issue_pred = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1'b1; issue_pc = 10'h100 + 10'(i);
            step();
        end
        issue_pc = 10'h108;
        n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_occ: got %0d expected 8", occupancy); end
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_issue_ready: got %b expected 0", issue_ready); end
        step(); step();
        n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_hold_occ: got %0d expected 8", occupancy); end
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        step();
        exp_correct = sat_inc(exp_correct);
        n_checks++; if (update_pc !== 10'h100) begin n_fail++; $display("FAIL full_first_pc: got %h expected 100", update_pc); end
        n_checks++; if (occupancy !== 4'd7) begin n_fail++; $display("FAIL full_no_passthrough: got %0d expected 7", occupancy); end
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: got %b expected 1", issue_ready); end
        step();
        issue_valid = 1'b0;
        exp_correct = sat_inc(exp_correct);
        n_checks++; if (update_pc !== 10'h101) begin n_fail++; $display("FAIL full_second_pc: got %h expected 101", update_pc); end
        n_checks++; if (occupancy !== 4'd7) begin n_fail++; $display("FAIL full_ninth_accepted: got %0d expected 7", occupancy); end
        for (int i = 2; i <= 8; i++) begin
            step();
            exp_correct = sat_inc(exp_correct);
            n_checks++; if (update_pc !== 10'h100 + 10'(i) || mispredict !== 1'b0) begin n_fail++; $display("FAIL full_order_%0d: got pc=%h mp=%b expected pc=%h mp=0", i, update_pc, mispredict, 10'h100 + 10'(i)); end
            $display("txn full_drain: update_pc=%h occupancy=%0d", update_pc, occupancy);
        end
        resolve_valid = 1'b0;
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL full_drained: got %0d expected 0", occupancy); end
        n_checks++; if (correct_count !== 4'(exp_correct)) begin n_fail++; $display("FAIL full_correct_count: got %0d expected %0d", correct_count, exp_correct); end
    endtask

    task automatic test_mispredict();
        issue_pred = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1; issue_pc = 10'h020 + 10'(i);
            step();
        end
        issue_pc = 10'h023; issue_pred = 1'b1;
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        step();
        exp_mis = sat_inc(exp_mis);
        n_checks++; if (mispredict !== 1'b1 || update_valid !== 1'b1) begin n_fail++; $display("FAIL mp_pulse: got mp=%b uv=%b expected 1/1", mispredict, update_valid); end
        n_checks++; if (update_pc !== 10'h020) begin n_fail++; $display("FAIL mp_update_pc: got %h expected 020", update_pc); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL mp_cleared: got %0d expected 0", occupancy); end
        n_checks++; if (mispredict_count !== 4'(exp_mis) || correct_count !== 4'(exp_correct)) begin n_fail++; $display("FAIL mp_counts: got %0d/%0d expected %0d/%0d", mispredict_count, correct_count, exp_mis, exp_correct); end
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) step();
            n_checks++; if (flushing !== 1'b1 || issue_ready !== 1'b0 || resolve_ready !== 1'b0) begin n_fail++; $display("FAIL mp_flush_cycle_%0d: got fl=%b ir=%b rr=%b expected 1/0/0", c, flushing, issue_ready, resolve_ready); end
            $display("txn flush_cycle %0d: flushing=%b", c, flushing);
        end
        n_checks++; if (update_valid !== 1'b0 || mispredict !== 1'b0) begin n_fail++; $display("FAIL mp_pulse_len: got uv=%b mp=%b expected 0/0", update_valid, mispredict); end
        issue_valid = 1'b0; resolve_valid = 1'b0;
        step();
        n_checks++; if (flushing !== 1'b0 || issue_ready !== 1'b1) begin n_fail++; $display("FAIL mp_exit: got fl=%b ir=%b expected 0/1", flushing, issue_ready); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL mp_discard: got %0d expected 0", occupancy); end
        issue_valid = 1'b1; issue_pc = 10'h030; issue_pred = 1'b0;
        step();
        issue_valid = 1'b0; resolve_valid = 1'b1; resolve_taken = 1'b0;
        step();
        resolve_valid = 1'b0;
        exp_correct = sat_inc(exp_correct);
        n_checks++; if (update_pc !== 10'h030 || mispredict !== 1'b0) begin n_fail++; $display("FAIL mp_fresh_queue: got pc=%h mp=%b expected 030/0", update_pc, mispredict); end
        $display("txn post_flush: update_pc=%h", update_pc);
    endtask

    task automatic test_back_to_back();
        issue_pred = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1; issue_pc = 10'h040 + 10'(i);
            step();
        end
        n_checks++; if (occupancy !== 4'd4) begin n_fail++; $display("FAIL b2b_fill: got %0d expected 4", occupancy); end
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue_pc = 10'h044 + 10'(k);
            step();
            exp_correct = sat_inc(exp_correct);
            n_checks++; if (occupancy !== 4'd4 || update_pc !== 10'h040 + 10'(k)) begin n_fail++; $display("FAIL b2b_same_cycle_%0d: got occ=%0d pc=%h expected 4/%h", k, occupancy, update_pc, 10'h040 + 10'(k)); end
            $display("txn b2b: update_pc=%h occupancy=%0d", update_pc, occupancy);
        end
        issue_valid = 1'b0;
        for (int k = 4; k < 8; k++) begin
            step();
            exp_correct = sat_inc(exp_correct);
            n_checks++; if (update_pc !== 10'h040 + 10'(k)) begin n_fail++; $display("FAIL b2b_wrap_order_%0d: got %h expected %h", k, update_pc, 10'h040 + 10'(k)); end
        end
        resolve_valid = 1'b0;
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d expected 0", occupancy); end
        n_checks++; if (correct_count !== 4'(exp_correct)) begin n_fail++; $display("FAIL b2b_correct_sat: got %0d expected %0d", correct_count, exp_correct); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) begin
            issue_valid = 1'b1; issue_pc = 10'h200 + 10'(i); issue_pred = 1'b0;
            step();
            issue_valid = 1'b0; resolve_valid = 1'b1; resolve_taken = 1'b1;
            step();
            resolve_valid = 1'b0;
            exp_mis = sat_inc(exp_mis);
            n_checks++; if (mispredict !== 1'b1 || mispredict_count !== 4'(exp_mis)) begin n_fail++; $display("FAIL sat_mp_%0d: got mp=%b cnt=%0d expected 1/%0d", i, mispredict, mispredict_count, exp_mis); end
            $display("txn sat: pc=%h mispredict_count=%0d", update_pc, mispredict_count);
            repeat (3) step();
        end
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_exit_ready: got %b expected 1", issue_ready); end
    endtask

    task automatic test_reset_flush();
        issue_pred = 1'b0;
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1'b1; issue_pc = 10'h300 + 10'(i);
            step();
        end
        issue_valid = 1'b0;
        n_checks++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL rf_occ: got %0d expected 2", occupancy); end
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        step();
        resolve_valid = 1'b0;
        step();
        n_checks++; if (flushing !== 1'b1) begin n_fail++; $display("FAIL rf_in_flush: got %b expected 1", flushing); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (flushing !== 1'b0 || occupancy !== 4'd0) begin n_fail++; $display("FAIL rf_state: got fl=%b occ=%0d expected 0/0", flushing, occupancy); end
        n_checks++; if (correct_count !== 4'd0 || mispredict_count !== 4'd0) begin n_fail++; $display("FAIL rf_counts: got %0d/%0d expected 0/0", correct_count, mispredict_count); end
        n_checks++; if (update_valid !== 1'b0 || mispredict !== 1'b0) begin n_fail++; $display("FAIL rf_update: got uv=%b mp=%b expected 0/0", update_valid, mispredict); end
        n_checks++; if (issue_ready !== 1'b1 || resolve_ready !== 1'b0) begin n_fail++; $display("FAIL rf_readies: got ir=%b rr=%b expected 1/0", issue_ready, resolve_ready); end
        step();
        n_checks++; if (flushing !== 1'b0) begin n_fail++; $display("FAIL rf_stays_run: got %b expected 0", flushing); end
        $display("txn reset_in_flush: flushing=%b occupancy=%0d", flushing, occupancy);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_mispredict();
        test_back_to_back();
        test_saturation();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
